cache_port_arbiter: RTL
=======================

// Module: cache_port_arbiter
// PURPOSE
//  Shares one cache_top instance between an instruction-fetch port (read-only) and a data port (read/write).
//  Owns the cache's MemRead/MemWrite/WoreAddress/DataIn and holds them stable while the cache stalls.
//  Returns read data and a one-cycle ack to the winning port. Counts stall cycles for performance monitoring.
// PARAMETERS
//  AW     10  word-address width (matches cache WoreAddress)
//  DW     32  data width
//  CNT_W  16  width of saturating stall-cycle counter
// PORTS
//  CLK          in   1   single clock, all state on rising edge
//  RST          in   1   synchronous, active-high reset
//  i_req        in   1   fetch request; hold until i_ack
//  i_addr       in   AW  fetch word address
//  i_ack        out  1   one-cycle completion pulse, fetch port
//  i_rdata      out  DW  fetch read data, valid while i_ack=1
//  d_req        in   1   data request; hold until d_ack
//  d_we         in   1   1=write, 0=read
//  d_addr       in   AW  data word address
//  d_wdata      in   DW  write data
//  d_ack        out  1   one-cycle completion pulse, data port
//  d_rdata      out  DW  data read data, valid while d_ack=1 and op was a read
//  c_read       out  1   to cache MemRead
//  c_write      out  1   to cache MemWrite
//  c_addr       out  AW  to cache WoreAddress
//  c_wdata      out  DW  to cache DataIn
//  c_stall      in   1   from cache stall
//  c_rdata      in   DW  from cache DataOut
//  gnt_d        out  1   1 while the data port owns the cache (BUSY or RESP)
//  stall_cnt    out  CNT_W  saturating count of BUSY cycles with c_stall=1
// BEHAVIOUR
//  FSM states: IDLE, BUSY, RESP. Registered state plus owner bit (0=fetch, 1=data).
//  IDLE:
//    - Cache outputs are 0.
//    - If any req=1, choose a winner and latch addr, we (0 for fetch) and wdata into internal regs.
//    - Then go to BUSY. If no req, stay in IDLE.
//  BUSY:
//    - c_read = ~we_r and c_write = we_r; c_addr and c_wdata are driven from the latched regs, stable for the whole state.
//    - If c_stall=0 this cycle, the operation is complete: latch c_rdata into the owner's rdata reg and go to RESP.
//    - Otherwise stay in BUSY and increment stall_cnt, saturating at all-ones.
//  RESP:
//    - The owner's ack=1 for exactly this cycle; c_read=c_write=0.
//    - Always go to IDLE next.
//  Latency: req sampled in IDLE at cycle 0 -> BUSY at cycle 1 -> ack at cycle 1+N+1, where N = stall cycles (hit: ack at cycle 2).
//  Max throughput is one op per 3 cycles.
//  Requester contract: keep req high with stable inputs until the ack cycle ends; req/addr may change on the edge ending the ack cycle.
//  Inputs are sampled only in IDLE. Dropping req before it is granted cancels it silently.
//  Arbitration (default): fixed priority, data wins over fetch when both req=1 in IDLE.
//  Loser is not latched; it retries on the next IDLE.
//  Requests arriving during BUSY/RESP wait; no queueing beyond req.
//  c_stall is ignored in IDLE and RESP.
//  c_rdata is latched on write completion too; d_rdata is don't-care after a write.
//  i_rdata/d_rdata hold their value until that port's next completion.
//  Reset (any state, including mid-BUSY):
//    - Next cycle: state=IDLE, all cache outputs 0, acks 0, rdata regs 0, stall_cnt 0, gnt_d 0, owner 0, rr pointer -> data preferred.
//    - An in-flight op is abandoned with no ack; the requester must re-issue it.
// CONFIGURATION
//  ROUND_ROBIN_EN defined:
//    - A 1-bit last-served pointer, updated on every RESP.
//    - When both ports request in IDLE, the port not served last wins; single requester always wins.
//    - After reset, data is preferred.
//  ROUND_ROBIN_EN undefined: fixed data-over-fetch priority; no pointer register.
// TESTING
//  T1 fetch hit: i_req=1, i_addr=10'h005, c_stall=0, c_rdata=32'hDEADBEEF -> c_read=1 cycle 1, i_ack=1 cycle 2, i_rdata=32'hDEADBEEF.
//  T2 data write with miss: d_req=1, d_we=1, d_addr=10'h3FF, d_wdata=32'h12345678, c_stall=1 for 4 cycles ->
//     c_write=1 and c_addr=10'h3FF stable 5 cycles, d_ack at cycle 6, stall_cnt=4, i_ack stays 0.
//  T3 contention: i_req=d_req=1 held for two ops each ->
//     default: both data ops complete (d_ack at 2, 5) before the first i_ack at 8;
//     ROUND_ROBIN_EN: order is D,I,D,I with acks at 2,5,8,11.
//  T4 reset mid-op: d_req read, c_stall=1, assert RST in BUSY cycle 2 ->
//     cycle 3: c_read=0, state IDLE, no d_ack, stall_cnt=0, d_rdata=0.
//  T5 cancel: d_req=1 arrives while the fetch op is in BUSY, deasserted before RESP ends -> no data op issued, no d_ack.
//  T6 saturation: CNT_W=4, c_stall=1 for 20 cycles -> stall_cnt sticks at 4'hF.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Two-port arbiter sharing one cache between instruction fetch and data access.
// Optional ROUND_ROBIN_EN selects alternating priority instead of fixed data-over-fetch.
module cache_port_arbiter #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_req,
    input  logic [AW-1:0]    i_addr,
    output logic             i_ack,
    output logic [DW-1:0]    i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [DW-1:0]    d_wdata,
    output logic             d_ack,
    output logic [DW-1:0]    d_rdata,
    output logic             c_read,
    output logic             c_write,
    output logic [AW-1:0]    c_addr,
    output logic [DW-1:0]    c_wdata,
    input  logic             c_stall,
    input  logic [DW-1:0]    c_rdata,
    output logic             gnt_d,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [DW-1:0]    i_rdata_q, i_rdata_d;
    logic [DW-1:0]    d_rdata_q, d_rdata_d;
    logic             i_ack_q, i_ack_d;
    logic             d_ack_q, d_ack_d;
    logic             c_read_q, c_read_d;
    logic             c_write_q, c_write_d;
    logic [AW-1:0]    c_addr_q, c_addr_d;
    logic [DW-1:0]    c_wdata_q, c_wdata_d;
    logic             gnt_d_q, gnt_d_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             pick_data;

`ifdef ROUND_ROBIN_EN
    // 0 = fetch served last, so data wins the next tie.
    logic last_q, last_d;
    assign pick_data = d_req & (~i_req | ~last_q);
`else
    assign pick_data = d_req;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        stall_cnt_d = stall_cnt_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        c_read_d    = 1'b0;
        c_write_d   = 1'b0;
        c_addr_d    = '0;
        c_wdata_d   = '0;
        gnt_d_d     = 1'b0;
`ifdef ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    owner_d   = pick_data;
                    we_d      = pick_data & d_we;
                    addr_d    = pick_data ? d_addr : i_addr;
                    wdata_d   = pick_data ? d_wdata : '0;
                    state_d   = S_BUSY;
                    c_read_d  = ~we_d;
                    c_write_d = we_d;
                    c_addr_d  = addr_d;
                    c_wdata_d = wdata_d;
                    gnt_d_d   = pick_data;
                end
            end
            S_BUSY: begin
                gnt_d_d = owner_q;
                if (!c_stall) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        d_rdata_d = c_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = c_rdata;
                        i_ack_d   = 1'b1;
                    end
                end else begin
                    c_read_d  = ~we_q;
                    c_write_d = we_q;
                    c_addr_d  = addr_q;
                    c_wdata_d = wdata_q;
                    if (stall_cnt_q != {CNT_W{1'b1}}) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef ROUND_ROBIN_EN
                last_d  = owner_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            c_read_q    <= 1'b0;
            c_write_q   <= 1'b0;
            c_addr_q    <= '0;
            c_wdata_q   <= '0;
            gnt_d_q     <= 1'b0;
            stall_cnt_q <= '0;
`ifdef ROUND_ROBIN_EN
            last_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            c_read_q    <= c_read_d;
            c_write_q   <= c_write_d;
            c_addr_q    <= c_addr_d;
            c_wdata_q   <= c_wdata_d;
            gnt_d_q     <= gnt_d_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef ROUND_ROBIN_EN
            last_q      <= last_d;
`endif
        end
    end

    assign i_ack     = i_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign c_read    = c_read_q;
    assign c_write   = c_write_q;
    assign c_addr    = c_addr_q;
    assign c_wdata   = c_wdata_q;
    assign gnt_d     = gnt_d_q;
    assign stall_cnt = stall_cnt_q;

endmodule
